// File: rtl/conv_pkg.sv
// Shared types and widths for the 3x3 convolution MAC sequencer.
package conv_pkg;

  localparam int unsigned LANES  = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 19;
  localparam int unsigned VEC_W  = LANES * DATA_W;
  localparam int unsigned CFG_CH_W  = 7;
  localparam int unsigned CFG_PIX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  // A zero channel count behaves as a single channel.
  function automatic logic [CFG_CH_W-1:0] eff_channels(input logic [CFG_CH_W-1:0] c);
    return (c == CFG_CH_W'(0)) ? CFG_CH_W'(1) : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through result FIFO; push and pop in the same cycle at full is legal.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == CNT_W'(0));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Feeds the 9-lane multiplier/adder tree, accumulates per-pixel channel sums
// and queues one signed result per pixel for the output writer.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned MAX_CH    = 64,
  parameter int unsigned TREE_LAT  = 2,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic [CFG_CH_W-1:0]     cfg_channels,
  input  logic [CFG_PIX_W-1:0]    cfg_pixels,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [VEC_W-1:0]        w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [VEC_W-1:0]        x_data,
  output logic [VEC_W-1:0]        multiplicand9,
  output logic [VEC_W-1:0]        multiplier9,
  input  logic signed [SUM_W-1:0] tree_sum,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [ACC_W-1:0] y_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned LI_W  = $clog2(TREE_LAT + 2);

  state_e                 state_q, state_d;
  logic [CFG_CH_W-1:0]    nch_q, nch_d;
  logic [CFG_PIX_W-1:0]   npix_q, npix_d, pix_q, pix_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [VEC_W-1:0]       wbuf_q [MAX_CH];
  logic signed [ACC_W-1:0] acc_q, acc_d, s, acc_sum;

  logic             w_acc, x_acc, last_beat, credit_ok;
  logic             out_vld, pipe_busy, fifo_empty;
  tag_t             tag_in, out_tag;
  logic [LI_W-1:0]  last_inflight;
  logic [CNT_W-1:0] fifo_cnt;

  assign last_beat = (CFG_CH_W'(ch_q) == nch_q - CFG_CH_W'(1));
  assign credit_ok = (32'(fifo_cnt) + 32'(last_inflight)) < OUT_DEPTH;
  assign w_acc     = w_valid & w_ready;
  assign x_acc     = x_valid & x_ready;
  assign busy      = (state_q != ST_IDLE);
  assign tag_in    = '{first: (ch_q == CH_W'(0)), last: last_beat};

  // Operands are forced to zero unless a window beat is accepted this cycle.
  assign multiplicand9 = x_acc ? x_data : '0;
  assign multiplier9   = x_acc ? wbuf_q[ch_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      nch_q   <= CFG_CH_W'(1);
      npix_q  <= '0;
      pix_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      nch_q   <= nch_d;
      npix_q  <= npix_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) wbuf_q[ch_q] <= w_data;
  end

  // ch_q doubles as the weight write index in LOAD_W and the channel in RUN.
  always_comb begin
    state_d = state_q;
    nch_d   = nch_q;
    npix_d  = npix_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    w_ready = 1'b0;
    x_ready = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          nch_d   = eff_channels(cfg_channels);
          npix_d  = cfg_pixels;
          pix_d   = '0;
          ch_d    = '0;
          state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (last_beat) begin
            ch_d    = '0;
            state_d = (npix_q == CFG_PIX_W'(0)) ? ST_DRAIN : ST_RUN;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      ST_RUN: begin
        x_ready = ~last_beat | credit_ok;
        if (x_valid && x_ready) begin
          if (last_beat) begin
            ch_d  = '0;
            pix_d = pix_q + CFG_PIX_W'(1);
            if (pix_q + CFG_PIX_W'(1) == npix_q) state_d = ST_DRAIN;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy && fifo_empty) begin
          done    = ~reset;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag pipe aligned with the tree latency; counts last-tagged beats for credit.
  if (TREE_LAT == 0) begin : g_pipe_comb
    assign out_vld       = x_acc;
    assign out_tag       = tag_in;
    assign pipe_busy     = 1'b0;
    assign last_inflight = '0;
  end else begin : g_pipe
    logic [TREE_LAT-1:0] vld_q;
    tag_t                tag_q [TREE_LAT];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < TREE_LAT; i++) begin
          vld_q[i] <= 1'b0;
          tag_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= x_acc;
        tag_q[0] <= tag_in;
        for (int unsigned i = 1; i < TREE_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end

    always_comb begin
      last_inflight = '0;
      for (int unsigned i = 0; i < TREE_LAT; i++) begin
        if (vld_q[i] && tag_q[i].last) last_inflight = last_inflight + LI_W'(1);
      end
    end

    assign out_vld   = vld_q[TREE_LAT-1];
    assign out_tag   = tag_q[TREE_LAT-1];
    assign pipe_busy = |vld_q;
  end

  assign s       = ACC_W'(tree_sum);
  assign acc_sum = out_tag.first ? s : acc_q + s;
  assign acc_d   = out_vld ? acc_sum : acc_q;

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  sync_fifo #(
    .WIDTH (ACC_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (out_vld & out_tag.last),
    .data_i  (acc_sum),
    .pop_i   (y_valid & y_ready),
    .data_o  (y_data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign y_valid = ~fifo_empty;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with a behavioural 9-lane multiplier
// and 2-stage reduction tree closing the loop.
module tb_conv_mac_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_start;
  logic [6:0]         cfg_channels;
  logic [15:0]        cfg_pixels;
  logic               w_valid, w_ready;
  logic [71:0]        w_data;
  logic               x_valid, x_ready;
  logic [71:0]        x_data;
  logic [71:0]        multiplicand9, multiplier9;
  logic signed [18:0] tree_sum;
  logic               y_valid, y_ready;
  logic signed [31:0] y_data;
  logic               busy, done;

  int checks   = 0;
  int failures = 0;
  int y_q[$];
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic busy_after_done = 1'bx;

  always #5 clk = ~clk;

  conv_mac_sequencer #(
    .MAX_CH    (64),
    .TREE_LAT  (2),
    .ACC_W     (32),
    .OUT_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_start     (cfg_start),
    .cfg_channels  (cfg_channels),
    .cfg_pixels    (cfg_pixels),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .x_data        (x_data),
    .multiplicand9 (multiplicand9),
    .multiplier9   (multiplier9),
    .tree_sum      (tree_sum),
    .y_valid       (y_valid),
    .y_ready       (y_ready),
    .y_data        (y_data),
    .busy          (busy),
    .done          (done)
  );

  function automatic logic signed [18:0] dot9(input logic [71:0] a, input logic [71:0] b);
    int acc;
    acc = 0;
    for (int k = 0; k < 9; k++) acc += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    return 19'(acc);
  endfunction

  logic signed [18:0] tp0, tp1;
  always @(posedge clk) begin
    tp0 <= dot9(multiplicand9, multiplier9);
    tp1 <= tp0;
  end
  assign tree_sum = tp1;

  // Result and done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (y_valid && y_ready) y_q.push_back(int'(y_data));
    if (done) done_cnt <= done_cnt + 1;
    if (done_prev) busy_after_done <= busy;
    done_prev <= done;
  end

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int y_at(input int i);
    return (i < y_q.size()) ? y_q[i] : 32'h7eadbeef;
  endfunction

  task automatic start_job(input int ch, input int pix);
    cfg_channels = 7'(ch);
    cfg_pixels   = 16'(pix);
    cfg_start    = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [71:0] d, input string tag);
    int got = 0;
    int cyc = 0;
    w_data  = d;
    w_valid = 1'b1;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (w_ready) got++;
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    check_val(tag, got, n);
  endtask

  task automatic send_x(input int ch, input int p0, input int npix, input int base,
                        input int step, input int bound, output int sent);
    int total = ch * npix;
    int got = 0;
    int cyc = 0;
    logic [7:0] v;
    x_valid = 1'b1;
    while (got < total && cyc < bound) begin
      @(negedge clk);
      cyc++;
      v = 8'(base + (p0 + got / ch) * step);
      x_data = {9{v}};
      if (x_ready) got++;
    end
    @(posedge clk); #1;
    x_valid = 1'b0;
    sent = got;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    check_val(tag, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, yb, db;
    reset = 1'b1; cfg_start = 1'b0; cfg_channels = '0; cfg_pixels = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_val("rst_outputs", {w_ready, x_ready, y_valid, busy, done}, 0);
    check_val("rst_operands", |{multiplicand9, multiplier9}, 0);

    // 1: single channel, single pixel
    yb = y_q.size(); db = done_cnt;
    start_job(1, 1);
    send_w(1, {9{8'h01}}, "t1_w");
    send_x(1, 0, 1, 1, 0, 50, sent);
    check_val("t1_sent", sent, 1);
    wait_idle("t1_idle");
    check_val("t1_count", y_q.size() - yb, 1);
    check_val("t1_y", y_at(yb), 9);
    check_val("t1_done", done_cnt - db, 1);
    check_val("t1_busy_after_done", busy_after_done, 0);

    // 2: three channels of -128 x -128
    yb = y_q.size(); db = done_cnt;
    start_job(3, 2);
    send_w(3, {9{8'h80}}, "t2_w");
    send_x(3, 0, 2, -128, 0, 100, sent);
    check_val("t2_sent", sent, 6);
    wait_idle("t2_idle");
    check_val("t2_count", y_q.size() - yb, 2);
    check_val("t2_y0", y_at(yb), 442368);
    check_val("t2_y1", y_at(yb + 1), 442368);

    // 3: backpressure limits pending results to the FIFO depth
    yb = y_q.size(); db = done_cnt;
    y_ready = 1'b0;
    start_job(1, 8);
    send_w(1, {9{8'h01}}, "t3_w");
    send_x(1, 0, 8, 1, 1, 20, sent);
    check_val("t3_sent_stalled", sent, 2);
    check_val("t3_x_ready_low", x_ready, 0);
    check_val("t3_y_valid", y_valid, 1);
    check_val("t3_no_pop", y_q.size() - yb, 0);
    y_ready = 1'b1;
    send_x(1, 2, 6, 1, 1, 100, sent);
    check_val("t3_sent_rest", sent, 6);
    wait_idle("t3_idle");
    check_val("t3_count", y_q.size() - yb, 8);
    for (int p = 0; p < 8; p++) check_val($sformatf("t3_y%0d", p), y_at(yb + p), 9 * (p + 1));

    // 4: full 64-channel depth, extreme operands
    yb = y_q.size();
    start_job(64, 1);
    send_w(64, {9{8'h7f}}, "t4_w");
    send_x(64, 0, 1, -128, 0, 200, sent);
    check_val("t4_sent", sent, 64);
    wait_idle("t4_idle");
    check_val("t4_y", y_at(yb), -9363456);

    // 5: reset in the middle of RUN, then a clean job
    yb = y_q.size(); db = done_cnt;
    start_job(2, 4);
    send_w(2, {9{8'h02}}, "t5_w");
    send_x(2, 0, 1, 1, 1, 50, sent);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("t5_rst_outputs", {w_ready, x_ready, y_valid, busy, done}, 0);
    check_val("t5_rst_operands", |{multiplicand9, multiplier9}, 0);
    repeat (6) @(posedge clk); #1;
    check_val("t5_no_done", done_cnt - db, 0);
    check_val("t5_no_y", y_q.size() - yb, 0);
    start_job(2, 4);
    send_w(2, {9{8'h02}}, "t5_w2");
    send_x(2, 0, 4, 1, 1, 100, sent);
    wait_idle("t5_idle");
    check_val("t5_count", y_q.size() - yb, 4);
    for (int p = 0; p < 4; p++) check_val($sformatf("t5_y%0d", p), y_at(yb + p), 36 * (p + 1));
    check_val("t5_done", done_cnt - db, 1);

    // 6a: zero-pixel job
    yb = y_q.size(); db = done_cnt;
    start_job(1, 0);
    check_val("t6_load_w_ready", w_ready, 1);
    send_w(1, {9{8'h01}}, "t6_w");
    check_val("t6_drain_done", done, 1);
    wait_idle("t6_idle");
    check_val("t6_no_y", y_q.size() - yb, 0);
    check_val("t6_done", done_cnt - db, 1);

    // 6b: cfg_start while running is ignored
    yb = y_q.size(); db = done_cnt;
    start_job(1, 2);
    send_w(1, {9{8'h01}}, "t6b_w");
    send_x(1, 0, 1, 1, 1, 50, sent);
    start_job(3, 5);
    send_x(1, 1, 1, 1, 1, 50, sent);
    check_val("t6b_sent", sent, 1);
    wait_idle("t6b_idle");
    check_val("t6b_count", y_q.size() - yb, 2);
    check_val("t6b_y1", y_at(yb + 1), 18);
    check_val("t6b_done", done_cnt - db, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
